// File: rtl/ws_pkg.sv
// ws_pkg: timing constants, pixel type and FSM encoding shared by the LED transmitter and receiver.
package ws_pkg;
  localparam int T0H = 300;
  localparam int T0L = 800;
  localparam int T1H = 800;
  localparam int T1L = 300;
  localparam int RST = 15000;
  localparam int T_BIT_THRESH = (T0H + T1H) / 2;
  typedef logic [23:0] pixel_t;
  localparam pixel_t OFF = 24'h000000;
  localparam pixel_t WHITE = 24'hFFFFFF;
  typedef enum logic [1:0] {WAIT_RST, IDLE, HIGH, LOW} state_t;
endpackage

// File: rtl/ws_din_sync.sv
// ws_din_sync: 2-flop synchronizer for the serial line plus rise/fall detection.
module ws_din_sync (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic din_s,
  output logic rise,
  output logic fall
);
  logic [2:0] sh;
  always_ff @(posedge clk or negedge rst)
    if (!rst) sh <= '0;
    else sh <= {sh[1:0], din};
  assign din_s = sh[1];
  assign rise = sh[1] & ~sh[2];
  assign fall = ~sh[1] & sh[2];
endmodule

// File: rtl/ws_rx_decoder.sv
// ws_rx_decoder: decodes the pulse-width LED line, captures the first 24-bit GRB pixel
// of each frame and forwards every later bit on dout, like a chained LED.
module ws_rx_decoder #(
  parameter int T_GLITCH = 50,
  parameter int T_BIT_THRESH = ws_pkg::T_BIT_THRESH,
  parameter int T_HIGH_MAX = 1500,
  parameter int T_RST = ws_pkg::RST,
  parameter int CNT_W = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        din,
  output logic [23:0] pixel_data,
  output logic        pixel_valid,
  output logic        frame_end,
  output logic        err,
  output logic        dout
);
  import ws_pkg::*;
  localparam logic [CNT_W-1:0] GL = CNT_W'(T_GLITCH);
  localparam logic [CNT_W-1:0] THR = CNT_W'(T_BIT_THRESH);
  localparam logic [CNT_W-1:0] HMAX = CNT_W'(T_HIGH_MAX);
  localparam logic [CNT_W-1:0] LRST = CNT_W'(T_RST);
  logic din_s, rise, fall;
  ws_din_sync u_sync (.clk(clk), .rst(rst), .din(din), .din_s(din_s), .rise(rise), .fall(fall));
  state_t state, state_d;
  logic [CNT_W-1:0] hcnt, lcnt;
  logic [4:0] bit_idx;
  logic latched;
  pixel_t shreg;
  logic fe, er, bit_ok, hclr, lclr, bit_v, last;
  assign bit_v = hcnt >= THR;
  assign last = bit_ok && !latched && bit_idx == 5'd23;
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= WAIT_RST;
    else state <= state_d;
  // A rise coinciding with the reset terminal count ends the frame and starts the next one.
  always_comb begin
    state_d = state;
    fe = 1'b0;
    er = 1'b0;
    bit_ok = 1'b0;
    hclr = 1'b0;
    lclr = 1'b0;
    case (state)
      WAIT_RST: if (lcnt >= LRST) begin
        fe = 1'b1;
        hclr = rise;
        state_d = rise ? HIGH : IDLE;
      end
      IDLE: if (rise) begin
        hclr = 1'b1;
        state_d = HIGH;
      end
      HIGH: if (hcnt >= HMAX || (fall && hcnt < GL)) begin
        er = 1'b1;
        lclr = 1'b1;
        state_d = WAIT_RST;
      end else if (fall) begin
        bit_ok = 1'b1;
        lclr = 1'b1;
        state_d = LOW;
      end
      LOW: if (lcnt >= LRST) begin
        fe = 1'b1;
        er = bit_idx != 5'd0 && !latched;
        hclr = rise;
        state_d = rise ? HIGH : IDLE;
      end else if (rise) begin
        hclr = 1'b1;
        state_d = HIGH;
      end
    endcase
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      hcnt <= '0;
      lcnt <= '0;
      bit_idx <= '0;
      latched <= 1'b0;
      shreg <= '0;
      pixel_data <= '0;
      pixel_valid <= 1'b0;
      frame_end <= 1'b0;
      err <= 1'b0;
      dout <= 1'b0;
    end else begin
      hcnt <= hclr ? '0 : state == HIGH ? hcnt + {{(CNT_W-1){1'b0}}, ~&hcnt} : hcnt;
      lcnt <= (lclr || (state == WAIT_RST && din_s)) ? '0 :
              (state == WAIT_RST || state == LOW) ? lcnt + {{(CNT_W-1){1'b0}}, ~&lcnt} : lcnt;
      frame_end <= fe;
      err <= er;
      pixel_valid <= last;
      dout <= latched ? din_s : 1'b0;
      if (last) pixel_data <= {shreg[22:0], bit_v};
      if (fe || er) begin
        bit_idx <= '0;
        latched <= 1'b0;
        shreg <= '0;
      end else if (bit_ok && !latched) begin
        shreg <= {shreg[22:0], bit_v};
        bit_idx <= last ? 5'd0 : bit_idx + 5'd1;
        latched <= last;
      end
    end
endmodule

// File: tb/tb_ws_rx_decoder.sv
// tb_ws_rx_decoder: directed scenarios for the LED line receiver, with all timing
// parameters scaled down 10x (0 = 30/80, 1 = 80/30, reset = 1500 low cycles).
module tb_ws_rx_decoder;
  logic clk = 1'b0, rst = 1'b0, din = 1'b0;
  logic [23:0] pixel_data;
  logic pixel_valid, frame_end, err, dout;
  int vec = 0, bad = 0;
  int npv = 0, nfe = 0, nerr = 0, nboth = 0, drun = 0;
  bit dever = 1'b0;
  logic [23:0] last_px = '0;
  int dw[$];

  ws_rx_decoder #(.T_GLITCH(5), .T_BIT_THRESH(55), .T_HIGH_MAX(150), .T_RST(1500), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .din(din), .pixel_data(pixel_data), .pixel_valid(pixel_valid),
    .frame_end(frame_end), .err(err), .dout(dout)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (pixel_valid) begin npv++; last_px = pixel_data; end
    if (frame_end) nfe++;
    if (err) nerr++;
    if (frame_end && err) nboth++;
    if (dout) begin drun++; dever = 1'b1; end
    else if (drun != 0) begin dw.push_back(drun); drun = 0; end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clr;
    npv = 0; nfe = 0; nerr = 0; nboth = 0; dever = 1'b0; dw.delete();
  endtask

  task automatic send_bit(input logic b);
    din = 1'b1; cyc(b ? 80 : 30);
    din = 1'b0; cyc(b ? 30 : 80);
  endtask

  task automatic send_word(input logic [23:0] w, input int n);
    for (int i = 23; i > 23 - n; i--) send_bit(w[i]);
  endtask

  task automatic idle_frame(input string tag);
    clr; din = 1'b0; cyc(1520);
    vec++; if (nfe !== 1) begin bad++; $display("FAIL %s frame_end count got %0d want 1", tag, nfe); end
    clr;
  endtask

  task automatic test_reset;
    cyc(4);
    vec++; if (pixel_data !== 24'h0) begin bad++; $display("FAIL reset pixel_data got %h want 000000", pixel_data); end
    vec++; if (pixel_valid !== 1'b0) begin bad++; $display("FAIL reset pixel_valid got %b want 0", pixel_valid); end
    vec++; if (frame_end !== 1'b0) begin bad++; $display("FAIL reset frame_end got %b want 0", frame_end); end
    vec++; if (err !== 1'b0) begin bad++; $display("FAIL reset err got %b want 0", err); end
    vec++; if (dout !== 1'b0) begin bad++; $display("FAIL reset dout got %b want 0", dout); end
    rst = 1'b1;
  endtask

  task automatic test_white;
    idle_frame("white_pre");
    send_word(24'hFFFFFF, 24); cyc(10);
    vec++; if (npv !== 1) begin bad++; $display("FAIL white pixel_valid count got %0d want 1", npv); end
    vec++; if (last_px !== 24'hFFFFFF) begin bad++; $display("FAIL white pixel got %h want ffffff", last_px); end
    vec++; if (dever !== 1'b0) begin bad++; $display("FAIL white dout got active want idle"); end
    vec++; if (nerr !== 0) begin bad++; $display("FAIL white err count got %0d want 0", nerr); end
  endtask

  task automatic test_pattern;
    idle_frame("pattern_pre");
    send_word(24'hA53C0F, 24); cyc(10);
    vec++; if (npv !== 1) begin bad++; $display("FAIL pattern pixel_valid count got %0d want 1", npv); end
    vec++; if (last_px !== 24'hA53C0F) begin bad++; $display("FAIL pattern pixel got %h want a53c0f", last_px); end
    vec++; if (nerr !== 0) begin bad++; $display("FAIL pattern err count got %0d want 0", nerr); end
  endtask

  task automatic test_back_to_back;
    logic [23:0] p2;
    int got, want;
    p2 = 24'h00FF00;
    idle_frame("b2b_pre");
    send_word(24'h123456, 24);
    vec++; if (last_px !== 24'h123456) begin bad++; $display("FAIL b2b first pixel got %h want 123456", last_px); end
    vec++; if (dever !== 1'b0) begin bad++; $display("FAIL b2b dout before forward got active want idle"); end
    din = 1'b1; cyc(2);
    vec++; if (dout !== 1'b0) begin bad++; $display("FAIL b2b dout at 2 cycles got %b want 0", dout); end
    cyc(1);
    vec++; if (dout !== 1'b1) begin bad++; $display("FAIL b2b dout at 3 cycles got %b want 1", dout); end
    cyc(27); din = 1'b0; cyc(80);
    send_word({p2[22:0], 1'b0}, 23); cyc(10);
    vec++; if (npv !== 1) begin bad++; $display("FAIL b2b pixel_valid count got %0d want 1", npv); end
    vec++; if (dw.size() !== 24) begin bad++; $display("FAIL b2b dout pulse count got %0d want 24", dw.size()); end
    for (int i = 0; i < 24; i++) begin
      got = (i < dw.size()) ? dw[i] : -1;
      want = p2[23-i] ? 80 : 30;
      vec++; if (got !== want) begin bad++; $display("FAIL b2b dout width bit %0d got %0d want %0d", i, got, want); end
    end
    clr; cyc(1520);
    vec++; if (nfe !== 1) begin bad++; $display("FAIL b2b frame_end count got %0d want 1", nfe); end
    vec++; if (nerr !== 0) begin bad++; $display("FAIL b2b err count got %0d want 0", nerr); end
    vec++; if (dout !== 1'b0) begin bad++; $display("FAIL b2b dout after frame got %b want 0", dout); end
    clr; send_word(24'h0F0F0F, 24); cyc(10);
    vec++; if (last_px !== 24'h0F0F0F) begin bad++; $display("FAIL b2b recapture got %h want 0f0f0f", last_px); end
    vec++; if (dever !== 1'b0) begin bad++; $display("FAIL b2b recapture dout got active want idle"); end
  endtask

  task automatic test_glitch;
    idle_frame("glitch_pre");
    send_word(24'hFFFFFF, 5);
    din = 1'b1; cyc(2); din = 1'b0; cyc(80);
    vec++; if (nerr !== 1) begin bad++; $display("FAIL glitch err count got %0d want 1", nerr); end
    vec++; if (npv !== 0) begin bad++; $display("FAIL glitch pixel_valid count got %0d want 0", npv); end
    clr; cyc(1520);
    vec++; if (nfe !== 1) begin bad++; $display("FAIL glitch frame_end count got %0d want 1", nfe); end
    vec++; if (nerr !== 0) begin bad++; $display("FAIL glitch stale err count got %0d want 0", nerr); end
    clr; send_word(24'hC3A5E1, 24); cyc(10);
    vec++; if (npv !== 1) begin bad++; $display("FAIL glitch pixel_valid after got %0d want 1", npv); end
    vec++; if (last_px !== 24'hC3A5E1) begin bad++; $display("FAIL glitch pixel got %h want c3a5e1", last_px); end
  endtask

  task automatic test_partial;
    idle_frame("partial_pre");
    send_word(24'hABC000, 12); cyc(1520);
    vec++; if (nfe !== 1) begin bad++; $display("FAIL partial frame_end count got %0d want 1", nfe); end
    vec++; if (nerr !== 1) begin bad++; $display("FAIL partial err count got %0d want 1", nerr); end
    vec++; if (nboth !== 1) begin bad++; $display("FAIL partial coincident pulses got %0d want 1", nboth); end
    vec++; if (npv !== 0) begin bad++; $display("FAIL partial pixel_valid count got %0d want 0", npv); end
    clr; send_word(24'h3C5A96, 24); cyc(10);
    vec++; if (last_px !== 24'h3C5A96) begin bad++; $display("FAIL partial next pixel got %h want 3c5a96", last_px); end
    vec++; if (nerr !== 0) begin bad++; $display("FAIL partial next err count got %0d want 0", nerr); end
  endtask

  task automatic test_high_max;
    idle_frame("hmax_pre");
    din = 1'b1; cyc(200); din = 1'b0; cyc(10);
    vec++; if (nerr !== 1) begin bad++; $display("FAIL hmax err count got %0d want 1", nerr); end
    vec++; if (npv !== 0) begin bad++; $display("FAIL hmax pixel_valid count got %0d want 0", npv); end
  endtask

  task automatic test_reset_mid;
    idle_frame("rstmid_pre");
    send_word(24'hFFFFFF, 9);
    din = 1'b1; cyc(40);
    rst = 1'b0; #1;
    vec++; if (pixel_data !== 24'h0) begin bad++; $display("FAIL rstmid pixel_data got %h want 000000", pixel_data); end
    vec++; if ({pixel_valid, frame_end, err, dout} !== 4'b0) begin bad++; $display("FAIL rstmid strobes got %b want 0000", {pixel_valid, frame_end, err, dout}); end
    cyc(5); rst = 1'b1; cyc(40); din = 1'b0; cyc(30);
    clr; send_word(24'hFFFFFF, 24); cyc(10);
    vec++; if (npv !== 0) begin bad++; $display("FAIL rstmid pixel_valid count got %0d want 0", npv); end
    vec++; if (nfe !== 0) begin bad++; $display("FAIL rstmid frame_end count got %0d want 0", nfe); end
    vec++; if (nerr !== 0) begin bad++; $display("FAIL rstmid err count got %0d want 0", nerr); end
    vec++; if (dever !== 1'b0) begin bad++; $display("FAIL rstmid dout got active want idle"); end
    vec++; if (pixel_data !== 24'h0) begin bad++; $display("FAIL rstmid held pixel got %h want 000000", pixel_data); end
    idle_frame("rstmid_recover");
    send_word(24'h5A5AA5, 24); cyc(10);
    vec++; if (last_px !== 24'h5A5AA5) begin bad++; $display("FAIL rstmid recapture got %h want 5a5aa5", last_px); end
  endtask

  initial begin
    @(negedge clk);
    test_reset;
    test_white;
    test_pattern;
    test_back_to_back;
    test_glitch;
    test_partial;
    test_high_max;
    test_reset_mid;
    $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
    $finish;
  end
endmodule
